// File: rtl/ftdi_rx_bridge.sv
// rtl/ftdi_rx_bridge.sv - FT2232H sync-245 receive front end with elastic byte buffer
//
// Drains bytes from the FTDI synchronous FIFO into a DEPTH-entry buffer and
// presents the head byte to the command parser as a valid/ack stream.
//
// Ports:
//   clk          system clock (FTDI CLKOUT domain)
//   nreset       synchronous reset, active low
//   ftdi_data    FTDI D[7:0], driven by the FTDI while OE# is low
//   ftdi_rxf_n   low when the FTDI holds a byte
//   ftdi_oe_n    FTDI output enable, active low, registered
//   ftdi_rd_n    FTDI read strobe, active low, registered
//   out_data     head byte of the buffer
//   out_valid    buffer non-empty
//   out_ack      consumer takes the head byte this cycle
//   level        current buffer occupancy, 0..DEPTH
//   overflow     sticky: a byte arrived while the buffer was full
module ftdi_rx_bridge #(
  parameter int DEPTH  = 8,
  parameter int MARGIN = 1
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic [7:0]               ftdi_data,
  input  logic                     ftdi_rxf_n,
  output logic                     ftdi_oe_n,
  output logic                     ftdi_rd_n,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // A burst may start only with enough room for the read that is in flight
  // when the stop decision is taken; it stops once MARGIN entries remain.
  localparam logic [LW-1:0] START_MAX = LW'(DEPTH - MARGIN - 2);
  localparam logic [LW:0]   STOP_AT   = (LW + 1)'(DEPTH - MARGIN);
  localparam logic [LW-1:0] FULL      = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OE,
    S_READ,
    S_STOP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            push;
  logic            pop;
  logic            full;
  logic            wr_en;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW:0]     level_after;
  logic [7:0]      mem [DEPTH];

  assign out_valid   = (level != '0);
  assign out_data    = mem[rd_ptr];
  assign pop         = out_valid && out_ack;
  assign full        = (level == FULL);
  // A push into a full buffer is only accepted when the head leaves on the same edge.
  assign wr_en       = push && (!full || pop);
  assign level_after = {1'b0, level} + {{LW{1'b0}}, push} - {{LW{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!ftdi_rxf_n && level <= START_MAX) state_nxt = S_OE;
      end
      S_OE: begin
        state_nxt = S_READ;
      end
      S_READ: begin
        push = !ftdi_rxf_n;
        if (ftdi_rxf_n || level_after >= STOP_AT) state_nxt = S_STOP;
      end
      S_STOP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state     <= S_IDLE;
      ftdi_oe_n <= 1'b1;
      ftdi_rd_n <= 1'b1;
    end else begin
      state     <= state_nxt;
      // Strobes are decoded from the next state so they switch together with it.
      ftdi_oe_n <= (state_nxt == S_IDLE);
      ftdi_rd_n <= (state_nxt != S_READ);
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)      level <= level + 1'b1;
      else if (!wr_en && pop) level <= level - 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // Buffer storage carries no reset; a reset edge never writes it.
  always_ff @(posedge clk) begin
    if (nreset && wr_en) mem[wr_ptr] <= ftdi_data;
  end

endmodule
